// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared definitions for the TRISC program-counter sequencer:
//            next-PC operation codes and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    // Next-PC operation codes presented by the decoder during EXEC.
    // Codes 6 and 7 are reserved and execute as OP_NEXT.
    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_stack
// Purpose  : Return-address LIFO, N bits wide and DEPTH entries deep.
//            The top entry is presented combinationally on dout so a pop
//            consumes it in the same cycle; the stack pointer moves on the
//            rising edge. Push and pop are never requested together.
// Ports    : clk   - system clock
//            clear - asynchronous active-low reset (empties the stack)
//            push  - write din above the current top
//            pop   - discard the current top
//            din   - value to push
//            dout  - current top entry (undefined when empty)
//            full  - DEPTH entries held
//            empty - no entries held
// Revision : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    // One extra bit so that "full" (sp == DEPTH) is representable.
    logic [AW:0]   r_sp;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    // DEPTH is a power of two, so the low AW bits of sp address the next
    // free slot and wrap to 0 exactly when the stack is full; the top entry
    // is always one slot below.
    assign w_wr_idx = r_sp[AW-1:0];
    assign w_rd_idx = w_wr_idx - AW'(1);

    assign full  = (r_sp == (AW+1)'(DEPTH));
    assign empty = (r_sp == '0);
    assign dout  = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - (AW+1)'(1);
        end
    end

    // Storage needs no reset: a cleared pointer makes old contents invisible.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter controller for the TRISC core. Steps through
//            IDLE -> FETCH -> EXEC (-> FETCH ...) and computes the next PC:
//            increment, jump, conditional branch, call/return through an
//            internal return-address stack, and halt.
// Ports    : clk       - system clock, rising edge
//            clear     - asynchronous active-low reset
//            start     - begin execution at PC 0 (sampled in IDLE only)
//            stall     - hold EXEC, no PC or stack change
//            op        - next-PC operation (valid in EXEC)
//            cond      - branch condition (valid with op)
//            target    - jump/branch/call destination (valid with op)
//            pc        - current program counter
//            fetch     - one-cycle strobe, instruction memory reads at pc
//            busy      - in FETCH or EXEC
//            halted    - in HALTED
//            stack_err - sticky stack overflow/underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         start,
    input  logic         stall,
    input  logic [2:0]   op,
    input  logic         cond,
    input  logic [N-1:0] target,
    output logic [N-1:0] pc,
    output logic         fetch,
    output logic         busy,
    output logic         halted,
    output logic         stack_err
);

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic         r_fetch;
    logic         r_stack_err;

    logic [N-1:0] w_pc_inc;
    logic         w_exec;
    logic         w_push;
    logic         w_pop;
    logic [N-1:0] w_top;
    logic         w_full;
    logic         w_empty;

    // Natural N-bit truncation gives the modulo-2^N increment.
    assign w_pc_inc = r_pc + N'(1);
    assign w_exec   = (r_state == ST_EXEC) && !stall;
    // Stack strobes are gated by full/empty so an erroring CALL/RET leaves
    // the stack untouched.
    assign w_push   = w_exec && (op == OP_CALL) && !w_full;
    assign w_pop    = w_exec && (op == OP_RET)  && !w_empty;

    ret_stack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_fetch     <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            // fetch is raised only on the edge that enters FETCH.
            r_fetch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_pc    <= '0;
                        r_fetch <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    r_state <= ST_EXEC;
                end

                ST_EXEC: begin
                    if (!stall) begin
                        r_state <= ST_FETCH;
                        r_fetch <= 1'b1;
                        case (op)
                            OP_JUMP: begin
                                r_pc <= target;
                            end
                            OP_BRANCH: begin
                                r_pc <= cond ? target : w_pc_inc;
                            end
                            OP_CALL: begin
                                if (w_full) begin
                                    r_stack_err <= 1'b1;
                                    r_state     <= ST_HALTED;
                                    r_fetch     <= 1'b0;
                                end else begin
                                    r_pc <= target;
                                end
                            end
                            OP_RET: begin
                                if (w_empty) begin
                                    r_stack_err <= 1'b1;
                                    r_state     <= ST_HALTED;
                                    r_fetch     <= 1'b0;
                                end else begin
                                    r_pc <= w_top;
                                end
                            end
                            OP_HALT: begin
                                r_state <= ST_HALTED;
                                r_fetch <= 1'b0;
                            end
                            default: begin
                                // OP_NEXT and the reserved codes
                                r_pc <= w_pc_inc;
                            end
                        endcase
                    end
                end

                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign fetch     = r_fetch;
    assign stack_err = r_stack_err;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign halted    = (r_state == ST_HALTED);

endmodule : pc_sequencer
`default_nettype wire
